pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/clkrst_pkg.sv | 36 +++
 rtl/pll_reset_seq_if.sv | 26 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_reset_seq.sv | 142 ++++++++++++++
 tb/tb_pll_reset_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkrst_pkg.sv
// Shared state encoding, default timing and small helpers for the clock/reset
// sequencing blocks.
package clkrst_pkg;

    localparam int unsigned PLL_RST_CYCLES_DEF = 32'd16;
    localparam int unsigned LOCK_TIMEOUT_DEF   = 32'd65535;
    localparam int unsigned STABLE_CYCLES_DEF  = 32'd1024;

    localparam int              RETRY_W   = 8;
    localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Saturating increment: the retry tally sticks at all-ones instead of wrapping.
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        if (v == RETRY_MAX) begin
            return v;
        end else begin
            return v + {{(RETRY_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic int unsigned max3_u(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Connection bundle between the reset sequencer and the PLL wrapper / PLL-domain logic.
interface pll_reset_seq_if;
    import clkrst_pkg::*;

    logic               pll_locked;
    logic               pll_resetb;
    logic               sys_reset;
    logic               ready;
    logic [RETRY_W-1:0] retry_count;

    modport master (
        input  pll_locked,
        output pll_resetb,
        output sys_reset,
        output ready,
        output retry_count
    );

    modport slave (
        output pll_locked,
        input  pll_resetb,
        input  sys_reset,
        input  ready,
        input  retry_count
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Capture stage followed by the settle stage; both clear on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses PLL RESETB, waits for a continuously stable lock,
// then releases the PLL-domain system reset; retries on lock timeout or loss.
module pll_reset_seq
    import clkrst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
    parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    pll_reset_seq_if.master bus
);
    localparam int unsigned CNT_MAX = max3_u(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int          CNT_W   = $clog2(CNT_MAX + 32'd1);

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(STABLE_CYCLES - 32'd1);

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               r_pll_resetb;
    logic               r_sys_reset;
    logic               r_ready;
    logic               w_pll_resetb_nxt;
    logic               w_sys_reset_nxt;
    logic               w_ready_nxt;
    logic               w_lk;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.pll_locked),
        .o_q   (w_lk)
    );

    // State, shared counter, retry tally and the registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= PLL_RST;
            r_cnt        <= CNT_ZERO;
            r_retry      <= {RETRY_W{1'b0}};
            r_pll_resetb <= 1'b0;
            r_sys_reset  <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_pll_resetb <= w_pll_resetb_nxt;
            r_sys_reset  <= w_sys_reset_nxt;
            r_ready      <= w_ready_nxt;
        end
    end

    // Next-state, counter and retry decisions; a lock seen on the timeout cycle wins
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        w_retry_nxt = r_retry;
        case (r_state)
            PLL_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = PLL_RST;
                end
            end
            WAIT_LOCK: begin
                if (w_lk) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == TIMEOUT_END) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = CNT_ZERO;
                    w_retry_nxt = sat_inc(r_retry);
                end else begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!w_lk) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == STABLE_END) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = STABLE;
                end
            end
            RUN: begin
                w_cnt_nxt = CNT_ZERO;
                if (!w_lk) begin
                    w_state_nxt = PLL_RST;
                    w_retry_nxt = sat_inc(r_retry);
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = PLL_RST;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Outputs decoded from the next state so they register together with the state
    always_comb begin
        w_pll_resetb_nxt = 1'b1;
        w_sys_reset_nxt  = 1'b1;
        w_ready_nxt      = 1'b0;
        case (w_state_nxt)
            PLL_RST: begin
                w_pll_resetb_nxt = 1'b0;
            end
            WAIT_LOCK, STABLE: begin
                w_pll_resetb_nxt = 1'b1;
            end
            RUN: begin
                w_sys_reset_nxt = 1'b0;
                w_ready_nxt     = 1'b1;
            end
            default: begin
                w_pll_resetb_nxt = 1'b0;
            end
        endcase
    end

    assign bus.pll_resetb  = r_pll_resetb;
    assign bus.sys_reset   = r_sys_reset;
    assign bus.ready       = r_ready;
    assign bus.retry_count = r_retry;
endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: a default-timed instance (A) and a short-timed instance (B).
// Snapshots are {pll_resetb, sys_reset, ready, retry_count[7:0]}.
module tb_pll_reset_seq;

    typedef struct {
        int          cyc;
        bit          drive;
        logic        lk;
        logic [10:0] exp;
        string       tag;
    } ev_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;
    int   cyc_a = 0;
    int   cyc_b = 0;
    ev_t  sb[$];
    int   lat_q[$];

    pll_reset_seq_if bus_a ();
    pll_reset_seq_if bus_b ();

    pll_reset_seq dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    pll_reset_seq #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) cyc_a <= 0;
        else       cyc_a <= cyc_a + 1;
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) cyc_b <= 0;
        else       cyc_b <= cyc_b + 1;
    end

    function automatic logic [10:0] st(input logic rb, input logic sr, input logic rd,
                                       input logic [7:0] rc);
        return {rb, sr, rd, rc};
    endfunction

    function automatic logic [10:0] snap_a();
        return {bus_a.pll_resetb, bus_a.sys_reset, bus_a.ready, bus_a.retry_count};
    endfunction

    function automatic logic [10:0] snap_b();
        return {bus_b.pll_resetb, bus_b.sys_reset, bus_b.ready, bus_b.retry_count};
    endfunction

    task automatic push_chk(input int c, input logic [10:0] v, input string t);
        ev_t e;
        e.cyc = c; e.drive = 1'b0; e.lk = 1'b0; e.exp = v; e.tag = t;
        sb.push_back(e);
    endtask

    task automatic push_drv(input int c, input logic v);
        ev_t e;
        e.cyc = c; e.drive = 1'b1; e.lk = v; e.exp = 11'd0; e.tag = "drive";
        sb.push_back(e);
    endtask

    task automatic goto_a(input int n);
        while (cyc_a < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_b(input int n);
        while (cyc_b < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart_a(input logic lk);
        rst_a = 1'b1;
        bus_a.pll_locked = lk;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    task automatic restart_b(input logic lk);
        rst_b = 1'b1;
        bus_b.pll_locked = lk;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
    endtask

    task automatic test_reset();
        ev_t e;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.pll_locked = 1'b0;
        bus_b.pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_chk(0, st(1'b0, 1'b1, 1'b0, 8'd0), "reset_a");
        push_chk(0, st(1'b0, 1'b1, 1'b0, 8'd0), "reset_b");
        e = sb.pop_front();
        total++;
        if (snap_a() !== e.exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", e.tag, snap_a(), e.exp);
        end
        e = sb.pop_front();
        total++;
        if (snap_b() !== e.exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", e.tag, snap_b(), e.exp);
        end
    endtask

    task automatic test_lock_nominal();
        ev_t e;
        int  lat;
        restart_a(1'b0);
        push_chk(15, st(1'b0, 1'b1, 1'b0, 8'd0), "nom_resetb_low_c15");
        push_chk(16, st(1'b1, 1'b1, 1'b0, 8'd0), "nom_resetb_high_c16");
        push_drv(116, 1'b1);
        push_chk(1000, st(1'b1, 1'b1, 1'b0, 8'd0), "nom_stable_hold");
        lat_q.push_back(16 + 100 + 2 + 1024 + 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            goto_a(e.cyc);
            if (e.drive) begin
                bus_a.pll_locked = e.lk;
            end else begin
                total++;
                if (snap_a() !== e.exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b", e.tag, cyc_a, snap_a(), e.exp);
                end
            end
        end
        while (bus_a.sys_reset === 1'b1 && cyc_a < 1300) begin
            @(posedge clk);
            #1;
        end
        lat = lat_q.pop_front();
        total++;
        if (cyc_a < lat - 1 || cyc_a > lat + 1) begin
            bad++;
            $display("FAIL nom_sys_reset_release cyc got=%0d want=%0d(+-1)", cyc_a, lat);
        end
        total++;
        if (snap_a() !== st(1'b1, 1'b0, 1'b1, 8'd0)) begin
            bad++;
            $display("FAIL nom_run_outputs got=%b want=%b", snap_a(), st(1'b1, 1'b0, 1'b1, 8'd0));
        end
    endtask

    task automatic test_glitch();
        ev_t e;
        restart_a(1'b0);
        push_drv(116, 1'b1);
        push_drv(618, 1'b0);
        push_drv(619, 1'b1);
        push_chk(1143, st(1'b1, 1'b1, 1'b0, 8'd0), "glitch_no_early_run");
        push_chk(1645, st(1'b1, 1'b1, 1'b0, 8'd0), "glitch_full_wait");
        push_chk(1646, st(1'b1, 1'b0, 1'b1, 8'd0), "glitch_run");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            goto_a(e.cyc);
            if (e.drive) begin
                bus_a.pll_locked = e.lk;
            end else begin
                total++;
                if (snap_a() !== e.exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b", e.tag, cyc_a, snap_a(), e.exp);
                end
            end
        end
    endtask

    task automatic test_run_loss();
        ev_t e;
        push_drv(1700, 1'b0);
        push_chk(1702, st(1'b1, 1'b0, 1'b1, 8'd0), "loss_still_run");
        push_chk(1703, st(1'b0, 1'b1, 1'b0, 8'd1), "loss_next_edge");
        push_chk(1718, st(1'b0, 1'b1, 1'b0, 8'd1), "loss_resetb_hold");
        push_chk(1719, st(1'b1, 1'b1, 1'b0, 8'd1), "loss_resetb_release");
        push_drv(1730, 1'b1);
        push_chk(2756, st(1'b1, 1'b1, 1'b0, 8'd1), "relock_wait");
        push_chk(2757, st(1'b1, 1'b0, 1'b1, 8'd1), "relock_run");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            goto_a(e.cyc);
            if (e.drive) begin
                bus_a.pll_locked = e.lk;
            end else begin
                total++;
                if (snap_a() !== e.exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b", e.tag, cyc_a, snap_a(), e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_async();
        ev_t e;
        goto_a(2800);
        #2;
        rst_a = 1'b1;
        #1;
        push_chk(0, st(1'b0, 1'b1, 1'b0, 8'd0), "async_reset_in_run");
        e = sb.pop_front();
        total++;
        if (snap_a() !== e.exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", e.tag, snap_a(), e.exp);
        end
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        push_chk(15, st(1'b0, 1'b1, 1'b0, 8'd0), "restart1_resetb_low");
        push_chk(16, st(1'b1, 1'b1, 1'b0, 8'd0), "restart1_resetb_high");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            goto_a(e.cyc);
            total++;
            if (snap_a() !== e.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%b want=%b", e.tag, cyc_a, snap_a(), e.exp);
            end
        end
        goto_a(500);
        #2;
        rst_a = 1'b1;
        #1;
        push_chk(0, st(1'b0, 1'b1, 1'b0, 8'd0), "async_reset_in_stable");
        e = sb.pop_front();
        total++;
        if (snap_a() !== e.exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", e.tag, snap_a(), e.exp);
        end
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        push_chk(16, st(1'b1, 1'b1, 1'b0, 8'd0), "restart2_resetb_high");
        push_chk(1040, st(1'b1, 1'b1, 1'b0, 8'd0), "restart2_stable_wait");
        push_chk(1041, st(1'b1, 1'b0, 1'b1, 8'd0), "restart2_run");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            goto_a(e.cyc);
            total++;
            if (snap_a() !== e.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%b want=%b", e.tag, cyc_a, snap_a(), e.exp);
            end
        end
    endtask

    task automatic test_timeout_first();
        ev_t e;
        restart_a(1'b0);
        push_chk(65550, st(1'b1, 1'b1, 1'b0, 8'd0), "timeout_not_yet");
        push_chk(65551, st(1'b0, 1'b1, 1'b0, 8'd1), "timeout_retry1");
        push_chk(65566, st(1'b0, 1'b1, 1'b0, 8'd1), "timeout_pll_rst_hold");
        push_chk(65567, st(1'b1, 1'b1, 1'b0, 8'd1), "timeout_wait_again");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            goto_a(e.cyc);
            total++;
            if (snap_a() !== e.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%b want=%b", e.tag, cyc_a, snap_a(), e.exp);
            end
        end
    endtask

    task automatic test_exact_timeout();
        ev_t e;
        restart_b(1'b0);
        push_chk(20, st(1'b1, 1'b1, 1'b0, 8'd0), "exact_waiting");
        push_drv(21, 1'b1);
        push_chk(24, st(1'b1, 1'b1, 1'b0, 8'd0), "exact_lock_wins");
        push_chk(31, st(1'b1, 1'b1, 1'b0, 8'd0), "exact_stable_wait");
        push_chk(32, st(1'b1, 1'b0, 1'b1, 8'd0), "exact_run");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            goto_b(e.cyc);
            if (e.drive) begin
                bus_b.pll_locked = e.lk;
            end else begin
                total++;
                if (snap_b() !== e.exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b", e.tag, cyc_b, snap_b(), e.exp);
                end
            end
        end
    endtask

    task automatic test_saturate();
        ev_t e;
        restart_b(1'b0);
        push_chk(24, st(1'b0, 1'b1, 1'b0, 8'd1), "sat_first_retry");
        push_chk(6119, st(1'b1, 1'b1, 1'b0, 8'd254), "sat_254");
        push_chk(6120, st(1'b0, 1'b1, 1'b0, 8'd255), "sat_reach_255");
        push_chk(6143, st(1'b1, 1'b1, 1'b0, 8'd255), "sat_wait_255");
        push_chk(6144, st(1'b0, 1'b1, 1'b0, 8'd255), "sat_hold_255");
        push_chk(6168, st(1'b0, 1'b1, 1'b0, 8'd255), "sat_hold_255_again");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            goto_b(e.cyc);
            total++;
            if (snap_b() !== e.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%b want=%b", e.tag, cyc_b, snap_b(), e.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_nominal();
        test_glitch();
        test_run_loss();
        test_reset_async();
        test_timeout_first();
        test_exact_timeout();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
